// File: rtl/spic_driver.sv
// spic_driver - instruction FIFO and read-response capture sitting between a host and an SPI master.
// The master is gated through master_en while it waits in its load state with no work or no response space.
module spic_driver #(
  parameter int INSTR_W = 50,
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_valid,
  input  logic [INSTR_W-1:0]         host_instr,
  input  logic [1:0]                 host_cfg,
  output logic                       host_ready,
  output logic                       err_unsup,
  output logic                       rsp_valid,
  output logic [DWIDTH-1:0]          rsp_data,
  input  logic                       rsp_ready,
  output logic                       master_en,
  output logic [INSTR_W-1:0]         driver_data,
  output logic [1:0]                 driver_cfg,
  input  logic                       driver_read,
  input  logic [DWIDTH-1:0]          spi_slv_read_data,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INSTR_W + 2;

  typedef enum logic [1:0] {IDLE, BUSY, STALL} state_t;

  state_t                 r_state, w_state_nxt;
  logic [EW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [INSTR_W-1:0]     r_cur_instr;
  logic [1:0]             r_cur_cfg;
  logic                   r_rd_pend;
  logic [1:0]             r_rd_size;
  logic                   r_rsp_valid;
  logic [DWIDTH-1:0]      r_rsp_data;
  logic                   r_err_unsup;

  logic                   w_full, w_empty, w_accept, w_unsup, w_push, w_pop;
  logic                   w_cap_ok, w_capture, w_master_en;
  logic [EW-1:0]          w_head;
  logic [INSTR_W-1:0]     w_head_instr;
  logic [1:0]             w_head_cfg, w_head_ttype, w_head_size;
  logic [DWIDTH-1:0]      w_cap_data;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_instr = w_head[EW-1:2];
  assign w_head_cfg   = w_head[1:0];
  assign w_head_ttype = w_head_instr[INSTR_W-3:INSTR_W-4];
  assign w_head_size  = w_head_instr[INSTR_W-5:INSTR_W-6];

  // Burst transfers and size 3 are accepted from the host but dropped here.
  assign w_accept  = host_valid && !w_full;
  assign w_unsup   = host_instr[INSTR_W-3] || (host_instr[INSTR_W-5:INSTR_W-6] == 2'b11);
  assign w_push    = w_accept && !w_unsup;

  assign w_cap_ok    = !r_rsp_valid || rsp_ready;
  assign w_master_en = !rst && (!driver_read || (!w_empty && !(r_rd_pend && !w_cap_ok)));
  assign w_pop       = driver_read && w_master_en && !w_empty;
  assign w_capture   = driver_read && r_rd_pend && w_cap_ok;

  always_comb begin
    w_cap_data = spi_slv_read_data;
    case (r_rd_size)
      2'd0:    w_cap_data = {{(DWIDTH-8){1'b0}}, spi_slv_read_data[7:0]};
      2'd1:    w_cap_data = {{(DWIDTH-16){1'b0}}, spi_slv_read_data[15:0]};
      default: w_cap_data = spi_slv_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {host_instr, host_cfg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cur_instr <= '0;
      r_cur_cfg   <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_size   <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_err_unsup <= 1'b0;
    end else begin
      r_err_unsup <= w_accept && w_unsup;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A pop in the capture cycle re-arms the pending flag for the next read.
      if (w_pop) begin
        r_cur_instr <= w_head_instr;
        r_cur_cfg   <= w_head_cfg;
        r_rd_pend   <= (w_head_ttype == 2'b00);
        r_rd_size   <= w_head_size;
      end else if (w_capture) begin
        r_rd_pend   <= 1'b0;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_cap_data;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty || r_rd_pend) w_state_nxt = BUSY;
      BUSY: begin
        if (driver_read && !w_master_en)   w_state_nxt = STALL;
        else if (w_empty && !r_rd_pend)    w_state_nxt = IDLE;
      end
      STALL: begin
        if (!(driver_read && !w_master_en))
          w_state_nxt = (w_empty && !r_rd_pend) ? IDLE : BUSY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign host_ready  = !w_full;
  assign err_unsup   = r_err_unsup;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign master_en   = w_master_en;
  assign driver_data = driver_read ? (w_empty ? '0 : w_head_instr) : r_cur_instr;
  assign driver_cfg  = driver_read ? (w_empty ? 2'b00 : w_head_cfg) : r_cur_cfg;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_spic_driver.sv
// tb_spic_driver - directed self-checking bench for spic_driver.
module tb_spic_driver;

  localparam int INSTR_W = 50;
  localparam int DWIDTH  = 32;
  localparam int DEPTH   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               host_valid;
  logic [INSTR_W-1:0] host_instr;
  logic [1:0]         host_cfg;
  logic               host_ready;
  logic               err_unsup;
  logic               rsp_valid;
  logic [DWIDTH-1:0]  rsp_data;
  logic               rsp_ready;
  logic               master_en;
  logic [INSTR_W-1:0] driver_data;
  logic [1:0]         driver_cfg;
  logic               driver_read;
  logic [DWIDTH-1:0]  spi_slv_read_data;
  logic [3:0]         fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  spic_driver #(.INSTR_W(INSTR_W), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_instr(host_instr), .host_cfg(host_cfg),
    .host_ready(host_ready), .err_unsup(err_unsup),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .master_en(master_en), .driver_data(driver_data), .driver_cfg(driver_cfg),
    .driver_read(driver_read), .spi_slv_read_data(spi_slv_read_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [1:0] tt, input logic [1:0] sz,
                                            input logic [31:0] d);
    return {2'b01, tt, sz, 12'h123, d};
  endfunction

  logic [INSTR_W-1:0] w_instr, r1, r2, w3;

  initial begin
    rst = 1'b1; host_valid = 1'b0; host_instr = '0; host_cfg = 2'b00;
    rsp_ready = 1'b0; driver_read = 1'b0; spi_slv_read_data = '0;
    step(); step();
    check("rst_master_en", master_en, 0);
    check("rst_count", fifo_count, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", err_unsup, 0);
    check("rst_driver_data", driver_data, 0);
    rst = 1'b0;
    #1;
    check("rst_host_ready", host_ready, 1);

    // Empty FIFO with master in load state: held off
    driver_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty_master_en", master_en, 0);
      check("empty_driver_data", driver_data, 0);
    end

    // Single write pass-through
    w_instr = mk(2'b01, 2'b00, 32'hCAFE_0001);
    host_valid = 1'b1; host_instr = w_instr; host_cfg = 2'b10;
    step();
    host_valid = 1'b0;
    #1;
    check("wr_master_en", master_en, 1);
    check("wr_driver_data", driver_data, w_instr);
    check("wr_driver_cfg", driver_cfg, 2'b10);
    check("wr_count", fifo_count, 1);
    step();
    check("wr_popped_count", fifo_count, 0);
    check("wr_after_pop_en", master_en, 0);
    driver_read = 1'b0;
    #1;
    check("wr_cur_instr", driver_data, w_instr);
    check("wr_cur_cfg", driver_cfg, 2'b10);
    check("wr_en_shift", master_en, 1);
    step(); step();
    check("wr_stable", driver_data, w_instr);
    check("wr_no_rsp", rsp_valid, 0);

    // Byte read
    r1 = mk(2'b00, 2'b00, 32'h0);
    driver_read = 1'b1; host_valid = 1'b1; host_instr = r1; host_cfg = 2'b01;
    step();
    host_valid = 1'b0;
    step();
    check("rd8_popped", fifo_count, 0);
    driver_read = 1'b0; spi_slv_read_data = 32'hA5A5_5A3C;
    step();
    driver_read = 1'b1;
    #1;
    check("rd8_cap_en", master_en, 0);
    step();
    check("rd8_valid", rsp_valid, 1);
    check("rd8_data", rsp_data, 32'h0000_003C);
    step();
    check("rd8_hold_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    check("rd8_consumed", rsp_valid, 0);
    rsp_ready = 1'b0; driver_read = 1'b0;

    // Back-to-back reads with response back-pressure
    r1 = mk(2'b00, 2'b01, 32'h0);
    r2 = mk(2'b00, 2'b10, 32'h0);
    w3 = mk(2'b01, 2'b00, 32'h3333);
    host_valid = 1'b1;
    host_instr = r1; step();
    host_instr = r2; step();
    host_instr = w3; step();
    host_valid = 1'b0;
    check("b2b_count3", fifo_count, 3);
    driver_read = 1'b1; spi_slv_read_data = 32'h1234_5678;
    #1;
    check("b2b_head_r1", driver_data, r1);
    step();
    driver_read = 1'b0;
    step();
    driver_read = 1'b1;
    #1;
    check("b2b_cap1_en", master_en, 1);
    step();
    check("b2b_rsp1_valid", rsp_valid, 1);
    check("b2b_rsp1_data", rsp_data, 32'h0000_5678);
    check("b2b_count1", fifo_count, 1);
    driver_read = 1'b0; spi_slv_read_data = 32'hDEAD_BEEF;
    step();
    driver_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("b2b_stall_en", master_en, 0);
      step();
      check("b2b_rsp1_hold", rsp_data, 32'h0000_5678);
      check("b2b_stall_count", fifo_count, 1);
    end
    rsp_ready = 1'b1;
    #1;
    check("b2b_release_en", master_en, 1);
    step();
    check("b2b_rsp2_valid", rsp_valid, 1);
    check("b2b_rsp2_data", rsp_data, 32'hDEAD_BEEF);
    check("b2b_pop_w3", fifo_count, 0);
    step();
    check("b2b_rsp2_done", rsp_valid, 0);
    rsp_ready = 1'b0; driver_read = 1'b0;

    // Fill to full, then push+pop one below full
    host_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      host_instr = mk(2'b01, 2'b00, 32'(i));
      step();
    end
    host_valid = 1'b0;
    check("full_count", fifo_count, DEPTH);
    check("full_ready", host_ready, 0);
    driver_read = 1'b1;
    step();
    check("full_pop1", fifo_count, DEPTH - 1);
    host_valid = 1'b1; host_instr = mk(2'b01, 2'b01, 32'h77);
    step();
    host_valid = 1'b0;
    check("full_pushpop", fifo_count, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) step();
    check("full_drained", fifo_count, 0);
    driver_read = 1'b0;

    // Unsupported instructions are discarded
    host_valid = 1'b1; host_instr = mk(2'b10, 2'b00, 32'h1);
    step();
    host_instr = mk(2'b00, 2'b11, 32'h2);
    #1;
    check("unsup_burst_err", err_unsup, 1);
    step();
    host_valid = 1'b0;
    #1;
    check("unsup_size_err", err_unsup, 1);
    check("unsup_count", fifo_count, 0);
    step();
    check("unsup_err_clear", err_unsup, 0);

    // Reset mid-transaction
    driver_read = 1'b1; host_valid = 1'b1; host_instr = mk(2'b00, 2'b10, 32'h0);
    step();
    step();
    host_instr = mk(2'b00, 2'b00, 32'h0);
    step();
    host_valid = 1'b0; driver_read = 1'b0;
    check("mid_count", fifo_count, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_en", master_en, 0);
    step();
    rst = 1'b0; driver_read = 1'b1; spi_slv_read_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_rsp", rsp_valid, 0);
    end
    check("mid_data", driver_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
